// File: rtl/prg_loader_pkg.sv
// Shared types and constants for the PRG loader: FSM states, default BASIC
// pointer / keyboard-buffer addresses and the autorun key string.
package prg_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_WAIT,
        S_PATCH,
        S_RUNKEY,
        S_DONE
    } state_t;

    localparam logic [15:0] VARTAB_ADDR       = 16'h002A;
    localparam logic [15:0] KBUF_ADDR_DEF     = 16'h026F;
    localparam logic [15:0] KBUF_CNT_ADDR_DEF = 16'h009E;

    localparam int KEY_LEN = 4;
    // Element [0] is typed first: "RUN" followed by carriage return.
    localparam logic [KEY_LEN-1:0][7:0] AUTORUN_KEYS = {8'h0D, 8'h4E, 8'h55, 8'h52};

    // Number of post-download writes: two bytes per pointer, plus the key
    // string and the key-count byte when autorun is enabled.
    function automatic logic [4:0] seq_len(input int nptr, input bit autorun);
        return 5'(2 * nptr + (autorun ? KEY_LEN + 1 : 0));
    endfunction

endpackage

// File: rtl/prg_loader_if.sv
// DMA write port between the PRG loader (master) and pet2001hw (slave).
interface prg_loader_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] dma_addr;
    logic [7:0]        dma_data;
    logic              dma_we;
    logic              dma_ready;

    modport master (output dma_addr, dma_data, dma_we, input dma_ready);
    modport slave  (input dma_addr, dma_data, dma_we, output dma_ready);
endinterface

// File: rtl/prg_loader_dma_seq_writer.sv
// Table-driven sequential DMA writer: pointer bytes first, then the autorun
// key string and key count. Advances one entry per accepted write.
module dma_seq_writer
    import prg_loader_pkg::*;
#(
    parameter int          ADDR_W        = 16,
    parameter int          NPTR          = 3,
    parameter logic [15:0] PTR_BASE      = VARTAB_ADDR,
    parameter logic [15:0] KBUF_ADDR     = KBUF_ADDR_DEF,
    parameter logic [15:0] KBUF_CNT_ADDR = KBUF_CNT_ADDR_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              clr,
    input  logic [15:0]       ptr_val,
    input  logic              dma_ready,
    output logic [4:0]        idx,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              wr_we,
    output logic              wr_accept
);

    localparam logic [4:0] NPW = 5'(2 * NPTR);

    logic [4:0]  idx_reg;
    logic [4:0]  key_idx;
    logic [15:0] addr16;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_reg <= '0;
        end else if (clr) begin
            idx_reg <= '0;
        end else if (wr_accept) begin
            idx_reg <= idx_reg + 5'd1;
        end
    end

    // Pointer k occupies entries 2k (low byte) and 2k+1 (high byte), so the
    // address is simply PTR_BASE + index.
    always_comb begin
        addr16  = '0;
        wr_data = '0;
        key_idx = idx_reg - NPW;
        if (idx_reg < NPW) begin
            addr16  = PTR_BASE + 16'(idx_reg);
            wr_data = idx_reg[0] ? ptr_val[15:8] : ptr_val[7:0];
        end else if (key_idx < 5'(KEY_LEN)) begin
            addr16  = KBUF_ADDR + 16'(key_idx);
            wr_data = AUTORUN_KEYS[key_idx[1:0]];
        end else begin
            addr16  = KBUF_CNT_ADDR;
            wr_data = 8'(KEY_LEN);
        end
    end

    assign idx       = idx_reg;
    assign wr_addr   = ADDR_W'(addr16);
    assign wr_we     = en;
    assign wr_accept = en & dma_ready;

endmodule

// File: rtl/prg_loader.sv
// PRG download loader: parses the load-address header, streams payload over a
// backpressured DMA port, then patches BASIC end pointers. Optional autorun
// keystroke injection is enabled by defining PRG_LOADER_AUTORUN_EN.
module prg_loader
    import prg_loader_pkg::*;
#(
    parameter int          ADDR_W        = 16,
    parameter logic [15:0] LOAD_LIMIT    = 16'h8000,
    parameter logic [15:0] PTR_BASE      = VARTAB_ADDR,
    parameter int          NPTR          = 3,
    parameter logic [15:0] KBUF_ADDR     = KBUF_ADDR_DEF,
    parameter logic [15:0] KBUF_CNT_ADDR = KBUF_CNT_ADDR_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [7:0]        dl_data,
    output logic              dl_wait,
    prg_loader_if.master      dma,
    output logic [ADDR_W-1:0] load_start,
    output logic [ADDR_W-1:0] load_end,
    output logic              busy,
    output logic              overflow,
    output logic              hdr_err,
    output logic              done
);

`ifdef PRG_LOADER_AUTORUN_EN
    localparam bit AUTORUN = 1'b1;
`else
    localparam bit AUTORUN = 1'b0;
`endif

    localparam logic [4:0] LAST_PTR = 5'(2 * NPTR - 1);
    localparam logic [4:0] LAST_KEY = seq_len(NPTR, 1'b1) - 5'd1;

    state_t            state_reg, state_next;
    logic              dl_active_q;
    logic [7:0]        hdr_lo_reg;
    logic [ADDR_W-1:0] load_start_reg, load_end_reg;
    logic [7:0]        pay_data_reg;
    logic              overflow_reg, hdr_err_reg;
    logic              fall_pend_reg, fall_pend_next;
    logic              abort_pend_reg, abort_pend_next;

    logic dl_rise, dl_fall;
    logic ovf_set, hdr_set, flags_clr;
    logic hdr_lo_we, hdr_hi_we, pay_we, end_inc;

    logic [4:0]        seq_idx;
    logic [ADDR_W-1:0] seq_addr;
    logic [7:0]        seq_data;
    logic              seq_we, seq_accept, seq_en;

    logic [ADDR_W-1:0] dma_addr_c;
    logic [7:0]        dma_data_c;
    logic              dma_we_c;

    assign dl_rise = dl_active & ~dl_active_q;
    assign dl_fall = ~dl_active & dl_active_q;
    assign seq_en  = (state_reg == S_PATCH) || (state_reg == S_RUNKEY);

    dma_seq_writer #(
        .ADDR_W        (ADDR_W),
        .NPTR          (NPTR),
        .PTR_BASE      (PTR_BASE),
        .KBUF_ADDR     (KBUF_ADDR),
        .KBUF_CNT_ADDR (KBUF_CNT_ADDR)
    ) u_seq (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (seq_en),
        .clr       (~seq_en),
        .ptr_val   (16'(load_end_reg)),
        .dma_ready (dma.dma_ready),
        .idx       (seq_idx),
        .wr_addr   (seq_addr),
        .wr_data   (seq_data),
        .wr_we     (seq_we),
        .wr_accept (seq_accept)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= S_IDLE;
            dl_active_q    <= 1'b0;
            hdr_lo_reg     <= '0;
            load_start_reg <= '0;
            load_end_reg   <= '0;
            pay_data_reg   <= '0;
            overflow_reg   <= 1'b0;
            hdr_err_reg    <= 1'b0;
            fall_pend_reg  <= 1'b0;
            abort_pend_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            dl_active_q    <= dl_active;
            fall_pend_reg  <= fall_pend_next;
            abort_pend_reg <= abort_pend_next;
            if (hdr_lo_we) hdr_lo_reg <= dl_data;
            if (hdr_hi_we) begin
                load_start_reg <= ADDR_W'({dl_data, hdr_lo_reg});
                load_end_reg   <= ADDR_W'({dl_data, hdr_lo_reg});
            end else if (end_inc) begin
                load_end_reg <= load_end_reg + ADDR_W'(1);
            end
            if (pay_we) pay_data_reg <= dl_data;
            if (flags_clr) begin
                overflow_reg <= 1'b0;
                hdr_err_reg  <= 1'b0;
            end else begin
                if (ovf_set) overflow_reg <= 1'b1;
                if (hdr_set) hdr_err_reg  <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        fall_pend_next  = fall_pend_reg;
        abort_pend_next = abort_pend_reg;
        ovf_set         = 1'b0;
        hdr_set         = 1'b0;
        flags_clr       = 1'b0;
        hdr_lo_we       = 1'b0;
        hdr_hi_we       = 1'b0;
        pay_we          = 1'b0;
        end_inc         = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (dl_rise) begin
                    state_next = S_HDR0;
                    flags_clr  = 1'b1;
                end
            end
            S_HDR0: begin
                if (dl_fall) begin
                    state_next = S_IDLE;
                    hdr_set    = 1'b1;
                end else if (dl_wr) begin
                    hdr_lo_we  = 1'b1;
                    state_next = S_HDR1;
                end
            end
            S_HDR1: begin
                if (dl_fall) begin
                    state_next = S_IDLE;
                    hdr_set    = 1'b1;
                end else if (dl_wr) begin
                    hdr_hi_we  = 1'b1;
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (dl_wr && (load_end_reg < ADDR_W'(LOAD_LIMIT))) begin
                    pay_we         = 1'b1;
                    fall_pend_next = dl_fall;
                    state_next     = S_WAIT;
                end else begin
                    if (dl_wr) ovf_set = 1'b1;
                    if (dl_fall) state_next = S_PATCH;
                end
            end
            S_WAIT: begin
                if (dl_wr) ovf_set = 1'b1;
                if (dl_fall) fall_pend_next = 1'b1;
                if (dma.dma_ready) begin
                    end_inc        = 1'b1;
                    fall_pend_next = 1'b0;
                    state_next     = (fall_pend_reg || dl_fall) ? S_PATCH : S_DATA;
                end
            end
            S_PATCH, S_RUNKEY: begin
                // A new download must not cut a presented write short, so a
                // rising edge is remembered until the current write lands.
                if (seq_accept) begin
                    abort_pend_next = 1'b0;
                    if (abort_pend_reg || dl_rise) begin
                        state_next = S_HDR0;
                        flags_clr  = 1'b1;
                    end else if (state_reg == S_PATCH && seq_idx == LAST_PTR) begin
                        state_next = AUTORUN ? S_RUNKEY : S_DONE;
                    end else if (state_reg == S_RUNKEY && seq_idx == LAST_KEY) begin
                        state_next = S_DONE;
                    end
                end else if (dl_rise) begin
                    abort_pend_next = 1'b1;
                end
            end
            S_DONE: begin
                if (dl_rise) begin
                    state_next = S_HDR0;
                    flags_clr  = 1'b1;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        dma_addr_c = '0;
        dma_data_c = '0;
        dma_we_c   = 1'b0;
        case (state_reg)
            S_WAIT: begin
                dma_addr_c = load_end_reg;
                dma_data_c = pay_data_reg;
                dma_we_c   = 1'b1;
            end
            S_PATCH, S_RUNKEY: begin
                dma_addr_c = seq_addr;
                dma_data_c = seq_data;
                dma_we_c   = seq_we;
            end
            default: ;
        endcase
    end

    assign dma.dma_addr = dma_addr_c;
    assign dma.dma_data = dma_data_c;
    assign dma.dma_we   = dma_we_c;

    assign dl_wait    = (state_reg == S_WAIT) || (state_reg == S_PATCH) || (state_reg == S_RUNKEY);
    assign busy       = (state_reg != S_IDLE);
    assign done       = (state_reg == S_DONE);
    assign load_start = load_start_reg;
    assign load_end   = load_end_reg;
    assign overflow   = overflow_reg;
    assign hdr_err    = hdr_err_reg;

endmodule

// File: tb/tb_prg_loader.sv
// Scoreboard bench for prg_loader: directed downloads push expected DMA writes
// and done pulses; a negedge monitor pops and compares them.
module tb_prg_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        dl_active, dl_wr, dl_wait;
    logic [7:0]  dl_data;
    logic [15:0] load_start, load_end;
    logic        busy, overflow, hdr_err, done;

    prg_loader_if #(.ADDR_W(16)) ifc ();

    prg_loader #(
        .ADDR_W        (16),
        .LOAD_LIMIT    (16'h8000),
        .PTR_BASE      (16'h002A),
        .NPTR          (3),
        .KBUF_ADDR     (16'h026F),
        .KBUF_CNT_ADDR (16'h009E)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .dl_active  (dl_active),
        .dl_wr      (dl_wr),
        .dl_data    (dl_data),
        .dl_wait    (dl_wait),
        .dma        (ifc.master),
        .load_start (load_start),
        .load_end   (load_end),
        .busy       (busy),
        .overflow   (overflow),
        .hdr_err    (hdr_err),
        .done       (done)
    );

    always #5 clk = ~clk;

`ifdef PRG_LOADER_AUTORUN_EN
    localparam int PATCH_LAT = 2 * 3 + 1 + 5;
`else
    localparam int PATCH_LAT = 2 * 3 + 1;
`endif

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  exp_done = 0;
    int  total = 0;
    int  bad = 0;
    bit  stall = 1'b0;
    int  scnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    // Monitor: every accepted DMA write and every done pulse is matched
    // against the scoreboard.
    always @(negedge clk) begin
        if (reset_n) begin
            if (ifc.dma_we && !dl_wait) begin
                total++;
                bad++;
                $display("FAIL dl_wait_during_write: got 0 want 1");
            end
            if (ifc.dma_we && ifc.dma_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got %h<-%h want none", ifc.dma_addr, ifc.dma_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    total++;
                    if (ifc.dma_addr !== mon_e.a || ifc.dma_data !== mon_e.d) begin
                        bad++;
                        $display("FAIL dma_write: got %h<-%h want %h<-%h",
                                 ifc.dma_addr, ifc.dma_data, mon_e.a, mon_e.d);
                    end else begin
                        $display("wr   %h <- %h", ifc.dma_addr, ifc.dma_data);
                    end
                end
            end
            if (done) begin
                total++;
                if (exp_done == 0) begin
                    bad++;
                    $display("FAIL unexpected_done: got 1 want 0");
                end else begin
                    exp_done--;
                    $display("done pulse");
                end
            end
        end
    end

    // Target model: ready either always high, or low for 5 cycles per write.
    initial begin
        ifc.dma_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (!stall) begin
                ifc.dma_ready = 1'b1;
                scnt = 0;
            end else if (ifc.dma_we) begin
                if (scnt == 5) begin
                    ifc.dma_ready = 1'b1;
                    scnt = 0;
                end else begin
                    ifc.dma_ready = 1'b0;
                    scnt++;
                end
            end else begin
                ifc.dma_ready = 1'b0;
                scnt = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        while (dl_wait && t < 60) begin
            tick(1);
            t++;
        end
        if (dl_wait) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got dl_wait=1 want 0");
        end
        dl_data = b;
        dl_wr   = 1'b1;
        tick(1);
        dl_wr   = 1'b0;
    endtask

    task automatic wait_nowait();
        int t = 0;
        while (dl_wait && t < 60) begin
            tick(1);
            t++;
        end
    endtask

    task automatic push_wr(input logic [15:0] a, input logic [7:0] d);
        exp_q.push_back('{a: a, d: d});
    endtask

    task automatic push_ptrs(input logic [15:0] v);
        for (int k = 0; k < 3; k++) begin
            push_wr(16'h002A + 16'(2 * k), v[7:0]);
            push_wr(16'h002B + 16'(2 * k), v[15:8]);
        end
`ifdef PRG_LOADER_AUTORUN_EN
        push_wr(16'h026F, 8'h52);
        push_wr(16'h0270, 8'h55);
        push_wr(16'h0271, 8'h4E);
        push_wr(16'h0272, 8'h0D);
        push_wr(16'h009E, 8'h04);
`endif
        exp_done++;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while ((busy || exp_q.size() != 0 || exp_done != 0) && t < 400) begin
            tick(1);
            t++;
        end
        chk({name, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_pending_done"}, 32'(exp_done), 32'd0);
        chk({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int cyc;
        reset_n   = 1'b0;
        dl_active = 1'b0;
        dl_wr     = 1'b0;
        dl_data   = 8'h00;
        tick(3);
        chk("rst_dma_we", 32'(ifc.dma_we), 32'd0);
        chk("rst_dma_addr", 32'(ifc.dma_addr), 32'd0);
        chk("rst_load_end", 32'(load_end), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flags", {29'd0, overflow, hdr_err, done}, 32'd0);
        chk("rst_dl_wait", 32'(dl_wait), 32'd0);
        reset_n = 1'b1;
        tick(2);

        // Basic load with ready tied high, plus patch latency
        stall = 1'b0;
        push_wr(16'h0401, 8'hA9);
        push_wr(16'h0402, 8'h00);
        push_wr(16'h0403, 8'h60);
        push_ptrs(16'h0404);
        dl_active = 1'b1;
        tick(2);
        send_byte(8'h01);
        send_byte(8'h04);
        send_byte(8'hA9);
        send_byte(8'h00);
        send_byte(8'h60);
        wait_nowait();
        dl_active = 1'b0;
        cyc = 0;
        while (cyc < 100) begin
            @(posedge clk);
            cyc++;
            #1;
            if (done) break;
        end
        chk("patch_latency", 32'(cyc), 32'(PATCH_LAT));
        wait_idle("basic");
        chk("basic_load_start", 32'(load_start), 32'h0401);
        chk("basic_load_end", 32'(load_end), 32'h0404);
        chk("basic_overflow", 32'(overflow), 32'd0);

        // Same stream with 5-cycle stalls per write
        stall = 1'b1;
        push_wr(16'h0401, 8'hA9);
        push_wr(16'h0402, 8'h00);
        push_wr(16'h0403, 8'h60);
        push_ptrs(16'h0404);
        dl_active = 1'b1;
        tick(2);
        send_byte(8'h01);
        send_byte(8'h04);
        send_byte(8'hA9);
        send_byte(8'h00);
        send_byte(8'h60);
        wait_nowait();
        dl_active = 1'b0;
        wait_idle("stall");
        chk("stall_load_end", 32'(load_end), 32'h0404);

        // Load limit: only 7FFE/7FFF stored
        stall = 1'b0;
        push_wr(16'h7FFE, 8'h11);
        push_wr(16'h7FFF, 8'h22);
        push_ptrs(16'h8000);
        dl_active = 1'b1;
        tick(2);
        send_byte(8'hFE);
        send_byte(8'h7F);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        wait_nowait();
        dl_active = 1'b0;
        wait_idle("limit");
        chk("limit_overflow", 32'(overflow), 32'd1);
        chk("limit_load_start", 32'(load_start), 32'h7FFE);
        chk("limit_load_end", 32'(load_end), 32'h8000);

        // Short header
        dl_active = 1'b1;
        tick(2);
        send_byte(8'h01);
        dl_active = 1'b0;
        tick(5);
        chk("short_hdr_err", 32'(hdr_err), 32'd1);
        chk("short_overflow_cleared", 32'(overflow), 32'd0);
        wait_idle("short");

        // Abort during PATCH, then a fresh download
        stall = 1'b1;
        push_wr(16'h7FFF, 8'hAA);
        push_wr(16'h002A, 8'h00);
        dl_active = 1'b1;
        tick(2);
        send_byte(8'hFF);
        send_byte(8'h7F);
        send_byte(8'hAA);
        send_byte(8'hBB);
        wait_nowait();
        dl_active = 1'b0;
        tick(2);
        dl_active = 1'b1;
        tick(8);
        chk("abort_overflow_cleared", 32'(overflow), 32'd0);
        chk("abort_hdr_err_cleared", 32'(hdr_err), 32'd0);
        chk("abort_busy", 32'(busy), 32'd1);
        chk("abort_writes_drained", 32'(exp_q.size()), 32'd0);
        push_wr(16'h2000, 8'h55);
        push_ptrs(16'h2001);
        send_byte(8'h00);
        send_byte(8'h20);
        send_byte(8'h55);
        wait_nowait();
        dl_active = 1'b0;
        wait_idle("abort");
        chk("abort_load_start", 32'(load_start), 32'h2000);
        chk("abort_load_end", 32'(load_end), 32'h2001);

        // Reset in the middle of a stalled payload write
        dl_active = 1'b1;
        tick(2);
        send_byte(8'h00);
        send_byte(8'h30);
        send_byte(8'h77);
        tick(2);
        chk("midrst_pre_we", 32'(ifc.dma_we), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("midrst_dma_we", 32'(ifc.dma_we), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_load_end", 32'(load_end), 32'd0);
        chk("midrst_dl_wait", 32'(dl_wait), 32'd0);
        dl_active = 1'b0;
        stall = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(4);
        chk("post_rst_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prg_loader.md
# prg_loader

Parametrised successor to the core's inline PRG loading logic. It consumes the byte stream from `data_io` for a PRG download and parses the 2-byte little-endian load-address header. Payload bytes go through a backpressured DMA write port into `pet2001hw`. After the download, it patches a configurable set of BASIC end-of-program pointers. It sits between `data_io` and the `dma_*` port of `pet2001hw` and replaces the fixed two-pointer, no-handshake loader.

## Interface
- `ADDR_W`, 16: DMA address width.
- `LOAD_LIMIT`, 16'h8000: first address that is not loadable. Payload at or above it is dropped.
- `PTR_BASE`, 16'h002A: address of the first patched pointer.
- `NPTR`, 3: number of 16-bit pointers patched, at `PTR_BASE+2k`, k = 0..NPTR-1 (VARTAB, ARYTAB, STREND). Range 1..8.
- `clk`  in  1  system clock (`clk_sys`).
- `reset_n`  in  1  asynchronous, active-low reset.
- `dl_active`  in  1  PRG download in progress (ioctl_download & index match).
- `dl_wr`  in  1  one-cycle strobe: `dl_data` valid.
- `dl_data`  in  8  download byte.
- `dl_wait`  out  1  backpressure to `data_io` (drives `ioctl_wait`).
- `dma_addr`  out  ADDR_W  write address.
- `dma_data`  out  8  write data.
- `dma_we`  out  1  write request, held until accepted.
- `dma_ready`  in  1  target accepts the write in a cycle where `dma_we & dma_ready`.
- `load_start`  out  ADDR_W  header address of the last load.
- `load_end`  out  ADDR_W  one past the last stored byte.
- `busy`  out  1  state ≠ IDLE.
- `overflow`  out  1  sticky: at least one byte dropped (limit or protocol violation). Cleared at the next load start.
- `hdr_err`  out  1  sticky: download ended with fewer than 2 bytes. Cleared at the next load start.
- `done`  out  1  one-cycle pulse when patching completes.

## Operation
- States: IDLE, HDR0, HDR1, DATA, WAIT, PATCH, DONE (plus RUNKEY, see Configuration).
- IDLE: a rising edge of `dl_active` → HDR0. On entry, clear `overflow` and `hdr_err`.
- HDR0: on `dl_wr`, latch the low byte → HDR1.
- HDR1: on `dl_wr`, latch the high byte; `load_start` = `load_end` = header address → DATA.
- DATA: on `dl_wr`:
  - if `load_end < LOAD_LIMIT`: drive `dma_addr=load_end`, `dma_data=dl_data`, `dma_we=1` → WAIT.
  - otherwise: drop the byte, set `overflow`, stay in DATA.
- WAIT: hold `dma_*` stable.
  - On `dma_we & dma_ready`: `load_end` += 1 (wraps modulo 2^ADDR_W, but the limit check prevents a wrap when LOAD_LIMIT ≤ 2^ADDR_W-1) → DATA.
  - A `dl_wr` arriving in WAIT is a protocol violation: the byte is dropped and `overflow` is set.
- Falling edge of `dl_active`:
  - in HDR0 or HDR1: set `hdr_err` → IDLE, no patch, no `done`.
  - in DATA: → PATCH.
  - in WAIT: the pending write completes first, then → PATCH.
- PATCH: sequential writes, each waiting for `dma_ready`, in order: `PTR_BASE+2k` ← `load_end[7:0]`, then `PTR_BASE+2k+1` ← `load_end[15:8]`, for k = 0..NPTR-1. Then → DONE.
- DONE: pulse `done` → IDLE.
- A rising edge of `dl_active` in PATCH, DONE or RUNKEY aborts the sequence → HDR0. A write already presented completes before the abort takes effect.

## Timing
- Reset values: all outputs 0; state IDLE.
- `dma_we` rises the cycle after the accepted `dl_wr` and stays high until the accept cycle. It falls the cycle after.
- `dl_wait` = 1 in WAIT, PATCH and RUNKEY; 0 otherwise (combinational from state).
- With `dma_ready` tied to 1: one payload byte may be accepted every 2 cycles; the patch phase takes 2·NPTR+1 cycles from the `dl_active` fall to `done`.
- Reset mid-operation: immediate return to IDLE with all outputs 0. A partially performed patch is not resumed.

## Configuration
- `PRG_LOADER_AUTORUN_EN` defined: after PATCH, a RUNKEY state writes 'R','U','N',8'h0D to `KBUF_ADDR`..+3 (parameter, default 16'h026F). It then writes 8'd4 to `KBUF_CNT_ADDR` (parameter, default 16'h009E), then → DONE. The patch latency grows by 5 writes.
- Undefined: PATCH → DONE directly. The two KBUF parameters exist but are unused.

## Structure
- Shared package `prg_loader_pkg`: the state enum, default address constants (VARTAB 16'h002A, KBUF 16'h026F, KBUF_CNT 16'h009E), and the autorun key-string constant.
- One natural sub-module, `dma_seq_writer`: takes a table index, presents address/data and handshakes with `dma_ready`. It is used by both PATCH and RUNKEY.

## Test plan
- Stream 01 04 A9 00 60, `dma_ready`=1 → writes 0401←A9, 0402←00, 0403←60. Then 002A←04, 002B←04, 002C←04, 002D←04, 002E←04, 002F←04 and a `done` pulse. `load_end`=16'h0404.
- Same stream with `dma_ready` low for 5 cycles per write → `dl_wait` high throughout each wait, no byte lost, identical final memory.
- Header 16'h7FFE plus 4 payload bytes → only 7FFE and 7FFF written, `overflow`=1, pointers patched to 16'h8000.
- `dl_active` low after a single byte → `hdr_err`=1, no DMA writes, no `done`.
- `dl_active` raised again during PATCH → sequence aborted, `overflow` and `hdr_err` cleared, new header parsed correctly.
- Autorun build → 026F..0272 = 52 55 4E 0D and 009E = 04, written after the pointers; then `done`.
